// File: rtl/clock_divider_bank.sv
// Bank of independent programmable clock dividers with rise/fall strobes and common phase sync.
// Outputs registered, one cycle after the sampling edge; no backpressure, divisor changes wait for a period boundary.
module clock_divider_bank #(
  parameter int CHANNELS    = 2,
  parameter int DIV_WIDTH   = 16,
  parameter int DEFAULT_DIV = 30
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [CHANNELS-1:0]  enable,
  input  logic [CHANNELS-1:0]  div_wr,
  input  logic [DIV_WIDTH-1:0] div_value,
  input  logic                 sync,
  output logic [CHANNELS-1:0]  clk_out,
  output logic [CHANNELS-1:0]  rise_tick,
  output logic [CHANNELS-1:0]  fall_tick,
  output logic [CHANNELS-1:0]  div_pending
);

  localparam logic [DIV_WIDTH-1:0] ONE = DIV_WIDTH'(1);
  localparam logic [DIV_WIDTH-1:0] TWO = DIV_WIDTH'(2);
  localparam logic [DIV_WIDTH-1:0] DEF = DIV_WIDTH'(DEFAULT_DIV);

  function automatic logic [DIV_WIDTH-1:0] eff(input logic [DIV_WIDTH-1:0] d);
    return (d < TWO) ? TWO : d;
  endfunction

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [DIV_WIDTH-1:0] act_q, act_d;
    logic [DIV_WIDTH-1:0] pdiv_q, pdiv_d;
    logic [DIV_WIDTH-1:0] high_d;
    logic                 pend_q, pend_d;
    logic                 en_q;
    logic                 clk_q, clk_d;
    logic                 rise_q, rise_d;
    logic                 fall_q, fall_d;
    logic                 wrap;
    logic                 boundary;

    assign wrap     = en_q && (cnt_q == eff(act_q) - ONE);
    assign boundary = sync || wrap;

    always_comb begin
      cnt_d  = cnt_q;
      act_d  = act_q;
      pdiv_d = pdiv_q;
      pend_d = pend_q;
      high_d = '0;
      clk_d  = 1'b0;
      rise_d = 1'b0;
      fall_d = 1'b0;
      if (!enable[i]) begin
        // Idle channel: divisor writes land directly, nothing is left pending.
        cnt_d  = '0;
        pend_d = 1'b0;
        if (div_wr[i]) begin
          act_d  = div_value;
          pdiv_d = div_value;
        end else if (pend_q) begin
          act_d = pdiv_q;
        end
      end else begin
        if (boundary || !en_q) cnt_d = '0;
        else                   cnt_d = cnt_q + ONE;
        if (boundary && pend_q) begin
          act_d  = pdiv_q;
          pend_d = 1'b0;
        end
        // A write coinciding with a boundary is held for the next one.
        if (div_wr[i]) begin
          pdiv_d = div_value;
          pend_d = 1'b1;
        end
        high_d = eff(act_d) >> 1;
        clk_d  = (cnt_d < high_d);
        rise_d = (cnt_d == '0);
        fall_d = (cnt_d == high_d);
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        cnt_q  <= '0;
        act_q  <= DEF;
        pdiv_q <= DEF;
        pend_q <= 1'b0;
        en_q   <= 1'b0;
        clk_q  <= 1'b0;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        act_q  <= act_d;
        pdiv_q <= pdiv_d;
        pend_q <= pend_d;
        en_q   <= enable[i];
        clk_q  <= clk_d;
        rise_q <= rise_d;
        fall_q <= fall_d;
      end
    end

    assign clk_out[i]     = clk_q;
    assign rise_tick[i]   = rise_q;
    assign fall_tick[i]   = fall_q;
    assign div_pending[i] = pend_q;
  end

endmodule
